// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM encoding, request
// opcode values and the word-index width helper.
package mem_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_COOL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP,
        S_COOL = ST_COOL
    } state_t;

    localparam logic OP_READ  = 1'b1;
    localparam logic OP_WRITE = 1'b0;

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// System-bus handshake between a cache Sys port (master) and the memory
// responder (slave).
interface mem_responder_if #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 32
);
    logic              mem_enable;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_data_in;
    logic [WORD_W-1:0] mem_data_out;
    logic              mem_ready;
    logic              mem_err;

    modport master (
        output mem_enable, mem_read, mem_write, mem_address, mem_data_in,
        input  mem_data_out, mem_ready, mem_err
    );

    modport slave (
        input  mem_enable, mem_read, mem_write, mem_address, mem_data_in,
        output mem_data_out, mem_ready, mem_err
    );
endinterface

// File: rtl/mem_array.sv
// Single-port synchronous word RAM; kept separate so a vendor macro can be
// dropped in without touching the responder FSM.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int WORD_W = 32,
    parameter int IDX_W  = index_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one request at a time, WAIT_CYCLES wait states,
// one-cycle ready pulse. MEM_RESPONDER_ERR_EN adds the misaligned-access flag.
//
// state  | meaning
// IDLE   | waiting for a read/write request; captures op, index, data
// WAIT   | counting wait states down to terminal count
// RESP   | commit write / fetch read; ready registered at end of cycle
// COOL   | dead cycle so a still-held strobe is not serviced twice
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int WORD_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int IDX_W = index_width(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              misalign_q;
    logic [WORD_W-1:0] data_out_q;
    logic              ready_q;
    logic              err_q;

    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  addr_idx;
    logic              req_read, req_write, req_valid, misalign;
    logic              capture, commit, ram_we;
    logic [IDX_W-1:0]  ram_index;
    logic [WORD_W-1:0] rdata;
    logic              unused_addr;

    assign addr        = bus.mem_address;
    assign addr_idx    = addr[IDX_W+1:2];
    assign unused_addr = ^addr;

    assign req_read  = bus.mem_enable & bus.mem_read;
    assign req_write = bus.mem_enable & bus.mem_write & ~bus.mem_read;
    assign req_valid = req_read | req_write;

`ifdef MEM_RESPONDER_ERR_EN
    assign misalign = |addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign capture   = (state_q == S_IDLE) & req_valid;
    assign commit    = (state_q == S_RESP);
    // Reset wins over a write committing in the same cycle.
    assign ram_we    = commit & (op_q == OP_WRITE) & ~misalign_q & ~rst;
    // Live address while idle so a zero-wait read has its word ready in RESP.
    assign ram_index = (state_q == S_IDLE) ? addr_idx : idx_q;

    mem_array #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .index (ram_index),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  state_d = S_COOL;
            S_COOL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= commit;
            err_q   <= commit & misalign_q;
            if (capture) begin
                cnt_q <= CNT_LOAD;
            end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (commit && (op_q == OP_READ) && !misalign_q) begin
                data_out_q <= rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            op_q       <= req_read ? OP_READ : OP_WRITE;
            idx_q      <= addr_idx;
            wdata_q    <= bus.mem_data_in;
            misalign_q <= misalign;
        end
    end

    assign bus.mem_data_out = data_out_q;
    assign bus.mem_ready    = ready_q;
    assign bus.mem_err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a WAIT_CYCLES=2 instance (sel 0) and a
// WAIT_CYCLES=0 instance (sel 1) on a shared clock and reset.
`timescale 1ns/1ps
module tb_mem_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(12), .WORD_W(32)) bus_w2 ();
    mem_responder_if #(.ADDR_W(12), .WORD_W(32)) bus_w0 ();

    mem_responder #(.ADDR_W(12), .WORD_W(32), .DEPTH(1024), .WAIT_CYCLES(2)) dut_w2 (
        .clk (clk), .rst (rst), .bus (bus_w2)
    );
    mem_responder #(.ADDR_W(12), .WORD_W(32), .DEPTH(1024), .WAIT_CYCLES(0)) dut_w0 (
        .clk (clk), .rst (rst), .bus (bus_w0)
    );

    exp_t        sb [$];
    logic [31:0] model [2][1024];
    logic [31:0] last_rd [2];
    int          total = 0;
    int          bad   = 0;

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus_w2.mem_ready : bus_w0.mem_ready;
    endfunction
    function automatic logic [31:0] get_data(input int sel);
        return (sel == 0) ? bus_w2.mem_data_out : bus_w0.mem_data_out;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus_w2.mem_err : bus_w0.mem_err;
    endfunction

    task automatic drive(input int sel, input logic en, input logic rd, input logic wr,
                         input logic [11:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus_w2.mem_enable = en; bus_w2.mem_read = rd; bus_w2.mem_write = wr;
            bus_w2.mem_address = a; bus_w2.mem_data_in = d;
        end else begin
            bus_w0.mem_enable = en; bus_w0.mem_read = rd; bus_w0.mem_write = wr;
            bus_w0.mem_address = a; bus_w0.mem_data_in = d;
        end
    endtask

    // One handshake; k counts edges from the capture edge (k=0).
    task automatic do_req(input int sel, input bit is_rd, input logic [11:0] addr,
                          input logic [31:0] wd, output bit seen, output int lat,
                          output int pulses, output logic [31:0] dout, output logic err,
                          output exp_t exp);
        int   idx = int'(addr[11:2]);
        bit   mis = 1'b0;
        exp_t e;
`ifdef MEM_RESPONDER_ERR_EN
        mis = (addr[1:0] != 2'b00);
`endif
        e.err  = mis;
        e.data = last_rd[sel];
        if (!mis) begin
            if (is_rd) begin
                e.data       = model[sel][idx];
                last_rd[sel] = e.data;
            end else begin
                model[sel][idx] = wd;
            end
        end
        sb.push_back(e);
        seen = 1'b0; lat = -1; pulses = 0; dout = '0; err = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, is_rd, ~is_rd, addr, wd);
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (get_ready(sel)) begin
                seen = 1'b1; lat = k; dout = get_data(sel); err = get_err(sel);
            end
        end
        exp = sb.pop_front();
        @(posedge clk); #1;
        if (get_ready(sel)) pulses++;
        drive(sel, 1'b0, 1'b0, 1'b0, addr, wd);
        repeat (4) begin
            @(posedge clk); #1;
            if (get_ready(sel)) pulses++;
        end
    endtask

    task automatic test_reset();
        int p [2];
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            total++;
            if (get_ready(s) !== 1'b0) begin bad++; $display("FAIL reset ready[%0d]: got %b want 0", s, get_ready(s)); end
            total++;
            if (get_data(s) !== 32'h0) begin bad++; $display("FAIL reset data[%0d]: got %h want 00000000", s, get_data(s)); end
            total++;
            if (get_err(s) !== 1'b0) begin bad++; $display("FAIL reset err[%0d]: got %b want 0", s, get_err(s)); end
        end
        @(negedge clk); rst = 1'b0;
        p = '{0, 0};
        repeat (4) begin
            @(posedge clk); #1;
            for (int s = 0; s < 2; s++) if (get_ready(s) !== 1'b0) p[s]++;
        end
        for (int s = 0; s < 2; s++) begin
            total++;
            if (p[s] != 0) begin bad++; $display("FAIL idle ready[%0d]: got %0d pulses want 0", s, p[s]); end
        end
    endtask

    task automatic test_write_read();
        bit rd_t [2] = '{1'b0, 1'b1};
        bit seen; int lat, pulses; logic [31:0] dout; logic err; exp_t e;
        for (int i = 0; i < 2; i++) begin
            do_req(0, rd_t[i], 12'h010, 32'hDEADBEEF, seen, lat, pulses, dout, err, e);
            total++;
            if (!seen) begin bad++; $display("FAIL wr_rd timeout[%0d]: got no ready want ready", i); end
            total++;
            if (lat != 3) begin bad++; $display("FAIL wr_rd latency[%0d]: got %0d want 3", i, lat); end
            total++;
            if (pulses != 0) begin bad++; $display("FAIL wr_rd width[%0d]: got %0d extra want 0", i, pulses); end
            total++;
            if (dout !== e.data || err !== e.err) begin
                bad++; $display("FAIL wr_rd data[%0d]: got %h/%b want %h/%b", i, dout, err, e.data, e.err);
            end
        end
    endtask

    task automatic test_zero_wait();
        bit rd_t [2] = '{1'b0, 1'b1};
        bit seen; int lat, pulses; logic [31:0] dout; logic err; exp_t e;
        for (int i = 0; i < 2; i++) begin
            do_req(1, rd_t[i], 12'h004, 32'h12345678, seen, lat, pulses, dout, err, e);
            total++;
            if (lat != 1) begin bad++; $display("FAIL zw latency[%0d]: got %0d want 1", i, lat); end
            total++;
            if (pulses != 0) begin bad++; $display("FAIL zw cool[%0d]: got %0d extra want 0", i, pulses); end
            total++;
            if (dout !== e.data || err !== e.err) begin
                bad++; $display("FAIL zw data[%0d]: got %h/%b want %h/%b", i, dout, err, e.data, e.err);
            end
        end
    endtask

    task automatic test_wrap();
        bit          rd_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [11:0] a_t  [4] = '{12'h7FC, 12'hFFC, 12'h7FC, 12'hFFC};
        logic [31:0] d_t  [4] = '{32'h11112222, 32'hA5A5A5A5, 32'h0, 32'h0};
        bit seen; int lat, pulses; logic [31:0] dout; logic err; exp_t e;
        for (int i = 0; i < 4; i++) begin
            do_req(0, rd_t[i], a_t[i], d_t[i], seen, lat, pulses, dout, err, e);
            total++;
            if (!seen || lat != 3 || pulses != 0) begin
                bad++; $display("FAIL wrap handshake[%0d]: got lat %0d extra %0d want lat 3 extra 0", i, lat, pulses);
            end
            total++;
            if (dout !== e.data || err !== e.err) begin
                bad++; $display("FAIL wrap data[%0d]: got %h/%b want %h/%b", i, dout, err, e.data, e.err);
            end
        end
    endtask

    task automatic test_misaligned();
        bit          rd_t [3] = '{1'b0, 1'b1, 1'b1};
        logic [11:0] a_t  [3] = '{12'h020, 12'h004, 12'h022};
        logic [31:0] d_t  [3] = '{32'hCAFE0008, 32'h0, 32'h0};
        bit seen; int lat, pulses; logic [31:0] dout; logic err; exp_t e;
        for (int i = 0; i < 3; i++) begin
            do_req(1, rd_t[i], a_t[i], d_t[i], seen, lat, pulses, dout, err, e);
            total++;
            if (!seen || lat != 1 || pulses != 0) begin
                bad++; $display("FAIL misalign handshake[%0d]: got lat %0d extra %0d want lat 1 extra 0", i, lat, pulses);
            end
            total++;
            if (dout !== e.data || err !== e.err) begin
                bad++; $display("FAIL misalign data[%0d]: got %h/%b want %h/%b", i, dout, err, e.data, e.err);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int abort_at [2] = '{0, 2};
        int p;
        bit seen; int lat, pulses; logic [31:0] dout; logic err; exp_t e;
        do_req(0, 1'b0, 12'h020, 32'h0BADF00D, seen, lat, pulses, dout, err, e);
        for (int i = 0; i < 2; i++) begin
            p = 0;
            @(negedge clk);
            drive(0, 1'b1, 1'b0, 1'b1, 12'h020, 32'h55AA55AA);
            for (int k = 0; k <= abort_at[i]; k++) begin
                @(posedge clk); #1;
                if (get_ready(0)) p++;
            end
            rst = 1'b1;
            @(posedge clk); #1;
            if (get_ready(0)) p++;
            total++;
            if (get_data(0) !== 32'h0) begin bad++; $display("FAIL abort data[%0d]: got %h want 00000000", i, get_data(0)); end
            rst = 1'b0;
            drive(0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
            repeat (3) begin
                @(posedge clk); #1;
                if (get_ready(0)) p++;
            end
            total++;
            if (p != 0) begin bad++; $display("FAIL abort ready[%0d]: got %0d pulses want 0", i, p); end
            last_rd[0] = 32'h0;
            last_rd[1] = 32'h0;
            do_req(0, 1'b1, 12'h020, 32'h0, seen, lat, pulses, dout, err, e);
            total++;
            if (!seen || dout !== e.data) begin
                bad++; $display("FAIL abort readback[%0d]: got %h want %h", i, dout, e.data);
            end
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        test_reset();
        test_write_read();
        test_zero_wait();
        test_wrap();
        test_misaligned();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
